// File: rtl/u409_decode_ack_engine_pkg.sv
// Shared types and constants for the U409 decode/ack engine.
// Holds the FSM state encoding, default widths and packed-bus slice helpers.
package u409_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_WAIT   = 3'd2,
        ST_TERM   = 3'd3,
        ST_NEGATE = 3'd4
    } state_t;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_WAIT_W = 4;
    localparam int DEF_TO_W   = 8;

    // Low bit of entry idx in a packed per-window bus of width-bit entries.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/u409_decode_ack_engine_if.sv
// 68040 local-bus view of the decode/ack engine.
// master = CPU/device side, slave = the engine.
interface u409_bus_if
    import u409_pkg::*;
#(
    parameter int NUM_WIN = 4,
    parameter int ADDR_W  = DEF_ADDR_W
) ();

    logic               nTS;
    logic               RnW;
    logic               OVL;
    logic [ADDR_W-1:0]  A;
    logic [NUM_WIN-1:0] EXT_ACK;
    logic [NUM_WIN-1:0] WIN_SEL;
    logic               nTA;
    logic               nTEA;
    logic               TERM_OE;
    logic               nTCI;
    logic               nTBI;
    logic               BUSY;

    modport master (
        output nTS, RnW, OVL, A, EXT_ACK,
        input  WIN_SEL, nTA, nTEA, TERM_OE, nTCI, nTBI, BUSY
    );

    modport slave (
        input  nTS, RnW, OVL, A, EXT_ACK,
        output WIN_SEL, nTA, nTEA, TERM_OE, nTCI, nTBI, BUSY
    );

endinterface

// File: rtl/u409_decode_ack_engine_window_match.sv
// Combinational priority matcher over NUM_WIN base/mask windows.
// Window 0 also claims masked-zero addresses while overlay is active.
module u409_window_match
    import u409_pkg::*;
#(
    parameter int NUM_WIN = 4,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0]         addr,
    input  logic                      ovl,
    input  logic [NUM_WIN*ADDR_W-1:0] win_base,
    input  logic [NUM_WIN*ADDR_W-1:0] win_mask,
    output logic [NUM_WIN-1:0]        sel_onehot,
    output logic                      hit
);

    logic [NUM_WIN-1:0] match;

    for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
        logic [ADDR_W-1:0] base_i;
        logic [ADDR_W-1:0] mask_i;
        assign base_i = win_base[slice_lo(i, ADDR_W) +: ADDR_W];
        assign mask_i = win_mask[slice_lo(i, ADDR_W) +: ADDR_W];
        if (i == 0) begin : g_ovl
            assign match[i] = (((addr ^ base_i) & mask_i) == '0) ||
                              (ovl && ((addr & mask_i) == '0));
        end else begin : g_std
            assign match[i] = (((addr ^ base_i) & mask_i) == '0);
        end
    end

    // Isolate the lowest set bit: lowest index wins.
    assign sel_onehot = match & (~match + NUM_WIN'(1));
    assign hit        = |match;

endmodule

// File: rtl/u409_decode_ack_engine.sv
// Programmable-window address decoder and nTA/nTEA terminator for the 68040 bus.
// Outputs are registered one cycle behind the FSM state.
//
//  state  | meaning
//  IDLE   | waiting for nTS
//  DECODE | compare captured address against windows, latch winner config
//  WAIT   | wait-state down-count or external-ack/timeout wait
//  TERM   | termination cycle (drives nTA or nTEA next cycle)
//  NEGATE | active negation of nTA/nTEA, then release
module u409_decode_ack_engine
    import u409_pkg::*;
#(
    parameter int NUM_WIN   = 4,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int WAIT_W    = DEF_WAIT_W,
    parameter int TO_CYCLES = 255,
    parameter int TO_W      = DEF_TO_W
) (
    input  logic                      CLK40,
    input  logic                      RESET,
    u409_bus_if.slave                 bus,
    input  logic [NUM_WIN*ADDR_W-1:0] WIN_BASE,
    input  logic [NUM_WIN*ADDR_W-1:0] WIN_MASK,
    input  logic [NUM_WIN*WAIT_W-1:0] WIN_WAIT,
    input  logic [NUM_WIN-1:0]        WIN_EXT,
    input  logic [NUM_WIN-1:0]        WIN_RO,
    input  logic [NUM_WIN-1:0]        WIN_TCI,
    input  logic [NUM_WIN-1:0]        WIN_TBI
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic                rnw_q, rnw_d;
    logic                ext_q, ext_d;
    logic                tci_q, tci_d;
    logic                tbi_q, tbi_d;
    logic                err_q, err_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]     to_q, to_d;

    logic [NUM_WIN-1:0]  win_sel_q, win_sel_d;
    logic                nta_q, nta_d;
    logic                ntea_q, ntea_d;
    logic                term_oe_q, term_oe_d;
    logic                ntci_q, ntci_d;
    logic                ntbi_q, ntbi_d;
    logic                busy_q, busy_d;

    logic [NUM_WIN-1:0]  match_onehot;
    logic                match_hit;
    logic [WAIT_W-1:0]   cand_wait;
    logic                cand_ext, cand_ro, cand_tci, cand_tbi;
    logic                ext_ack_hit;

    u409_window_match #(
        .NUM_WIN (NUM_WIN),
        .ADDR_W  (ADDR_W)
    ) u_match (
        .addr       (a_q),
        .ovl        (bus.OVL),
        .win_base   (WIN_BASE),
        .win_mask   (WIN_MASK),
        .sel_onehot (match_onehot),
        .hit        (match_hit)
    );

    always_comb begin
        cand_wait = '0;
        cand_ext  = 1'b0;
        cand_ro   = 1'b0;
        cand_tci  = 1'b0;
        cand_tbi  = 1'b0;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (match_onehot[i]) begin
                cand_wait = WIN_WAIT[slice_lo(i, WAIT_W) +: WAIT_W];
                cand_ext  = WIN_EXT[i];
                cand_ro   = WIN_RO[i];
                cand_tci  = WIN_TCI[i];
                cand_tbi  = WIN_TBI[i];
            end
        end
    end

    // win_sel_q is already valid while in WAIT, so it gates EXT_ACK.
    assign ext_ack_hit = |(bus.EXT_ACK & win_sel_q);

    always_ff @(posedge CLK40 or posedge RESET) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        rnw_d   = rnw_q;
        ext_d   = ext_q;
        tci_d   = tci_q;
        tbi_d   = tbi_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.nTS) begin
                    a_d     = bus.A;
                    rnw_d   = bus.RnW;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ext_d = cand_ext;
                tci_d = cand_tci;
                tbi_d = cand_tbi;
                err_d = !match_hit || (cand_ro && !rnw_q);
                cnt_d = cand_wait;
                to_d  = '0;
                if (err_d || (!cand_ext && cand_wait == '0)) state_d = ST_TERM;
                else                                          state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ext_q) begin
                    if (ext_ack_hit) begin
                        state_d = ST_TERM;
                    end else if (to_q == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_TERM;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end else if (cnt_q <= WAIT_W'(1)) begin
                    state_d = ST_TERM;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            ST_TERM:   state_d = ST_NEGATE;
            ST_NEGATE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        nta_d     = 1'b1;
        ntea_d    = 1'b1;
        ntci_d    = 1'b1;
        ntbi_d    = 1'b1;
        term_oe_d = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        win_sel_d = win_sel_q;
        case (state_q)
            ST_IDLE:   win_sel_d = '0;
            ST_DECODE: win_sel_d = match_onehot;
            ST_TERM: begin
                term_oe_d = 1'b1;
                if (err_q) begin
                    ntea_d = 1'b0;
                end else begin
                    nta_d  = 1'b0;
                    ntci_d = !tci_q;
                    ntbi_d = !tbi_q;
                end
            end
            ST_NEGATE: begin
                term_oe_d = 1'b1;
                win_sel_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK40 or posedge RESET) begin
        if (RESET) begin
            a_q       <= '0;
            rnw_q     <= 1'b1;
            ext_q     <= 1'b0;
            tci_q     <= 1'b0;
            tbi_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            to_q      <= '0;
            win_sel_q <= '0;
            nta_q     <= 1'b1;
            ntea_q    <= 1'b1;
            term_oe_q <= 1'b0;
            ntci_q    <= 1'b1;
            ntbi_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            a_q       <= a_d;
            rnw_q     <= rnw_d;
            ext_q     <= ext_d;
            tci_q     <= tci_d;
            tbi_q     <= tbi_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            win_sel_q <= win_sel_d;
            nta_q     <= nta_d;
            ntea_q    <= ntea_d;
            term_oe_q <= term_oe_d;
            ntci_q    <= ntci_d;
            ntbi_q    <= ntbi_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.WIN_SEL = win_sel_q;
    assign bus.nTA     = nta_q;
    assign bus.nTEA    = ntea_q;
    assign bus.TERM_OE = term_oe_q;
    assign bus.nTCI    = ntci_q;
    assign bus.nTBI    = ntbi_q;
    assign bus.BUSY    = busy_q;

endmodule

// File: tb/tb_u409_decode_ack_engine.sv
// Directed bench for u409_decode_ack_engine: vector table for single transfers
// plus hand sequences for external ack, timeout, ignored nTS, back-to-back and reset abort.
module tb_u409_decode_ack_engine;

    typedef struct {
        logic [19:0] a;
        logic        rnw;
        logic        ovl;
        logic [3:0]  sel;
        logic        err;
        int          lat;
        logic        ntci;
        logic        ntbi;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] win_base;
    logic [79:0] win_mask;
    logic [15:0] win_wait;
    logic [3:0]  win_ext, win_ro, win_tci, win_tbi;

    int n_cmp = 0;
    int n_err = 0;

    u409_bus_if #(.NUM_WIN(4), .ADDR_W(20)) bus ();

    u409_decode_ack_engine #(
        .NUM_WIN(4), .ADDR_W(20), .WAIT_W(4), .TO_CYCLES(255), .TO_W(8)
    ) dut (
        .CLK40    (clk),
        .RESET    (rst),
        .bus      (bus),
        .WIN_BASE (win_base),
        .WIN_MASK (win_mask),
        .WIN_WAIT (win_wait),
        .WIN_EXT  (win_ext),
        .WIN_RO   (win_ro),
        .WIN_TCI  (win_tci),
        .WIN_TBI  (win_tbi)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives nTS low so that it is sampled at the next edge (edge 0).
    task automatic start(input logic [19:0] a, input logic rnw);
        bus.A   = a;
        bus.RnW = rnw;
        bus.nTS = 1'b0;
        tick();
        bus.nTS = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        bus.OVL = v.ovl;
        start(v.a, v.rnw);
        for (int e = 1; e <= v.lat + 2; e++) begin
            tick();
            chk($sformatf("v%0d_nTA_e%0d", id, e), bus.nTA, (e == v.lat && !v.err) ? 0 : 1);
            chk($sformatf("v%0d_nTEA_e%0d", id, e), bus.nTEA, (e == v.lat && v.err) ? 0 : 1);
            chk($sformatf("v%0d_OE_e%0d", id, e), bus.TERM_OE, (e == v.lat || e == v.lat + 1) ? 1 : 0);
            chk($sformatf("v%0d_BUSY_e%0d", id, e), bus.BUSY, (e <= v.lat) ? 1 : 0);
            if (e == v.lat) begin
                chk($sformatf("v%0d_SEL", id), bus.WIN_SEL, v.sel);
                chk($sformatf("v%0d_nTCI", id), bus.nTCI, v.ntci);
                chk($sformatf("v%0d_nTBI", id), bus.nTBI, v.ntbi);
            end
        end
        bus.OVL = 1'b0;
        tick();
    endtask

    vec_t vecs[9];

    initial begin
        int cnt_ta, cnt_tea, first_e, second_e, last_e;

        //          a          rnw   ovl   sel      err   lat ntci  ntbi
        vecs[0] = '{20'hBFD12, 1'b1, 1'b0, 4'b0010, 1'b0, 5,  1'b0, 1'b1};
        vecs[1] = '{20'h00000, 1'b1, 1'b1, 4'b0001, 1'b0, 2,  1'b1, 1'b0};
        vecs[2] = '{20'h00000, 1'b1, 1'b0, 4'b0000, 1'b1, 2,  1'b1, 1'b1};
        vecs[3] = '{20'h00F85, 1'b1, 1'b0, 4'b0001, 1'b0, 2,  1'b1, 1'b0};
        vecs[4] = '{20'h00F85, 1'b0, 1'b0, 4'b0001, 1'b1, 2,  1'b1, 1'b1};
        vecs[5] = '{20'hBF123, 1'b1, 1'b0, 4'b1000, 1'b0, 17, 1'b1, 1'b0};
        vecs[6] = '{20'hBFD12, 1'b0, 1'b0, 4'b0010, 1'b0, 5,  1'b0, 1'b1};
        vecs[7] = '{20'h12345, 1'b1, 1'b0, 4'b0000, 1'b1, 2,  1'b1, 1'b1};
        vecs[8] = '{20'h00010, 1'b1, 1'b1, 4'b0001, 1'b0, 2,  1'b1, 1'b0};

        // win3 overlaps win1; win2 is external-ack; win0 is read-only ROM.
        win_base = {20'hBF000, 20'hE0000, 20'hBFD00, 20'h00F80};
        win_mask = {20'hFF000, 20'hFF000, 20'hFFF00, 20'hFFFC0};
        win_wait = {4'hF, 4'h0, 4'h3, 4'h0};
        win_ext  = 4'b0100;
        win_ro   = 4'b0001;
        win_tci  = 4'b0110;
        win_tbi  = 4'b1101;

        bus.nTS = 1'b1; bus.RnW = 1'b1; bus.OVL = 1'b0; bus.A = '0; bus.EXT_ACK = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_nTA", bus.nTA, 1);
        chk("rst_nTEA", bus.nTEA, 1);
        chk("rst_nTCI", bus.nTCI, 1);
        chk("rst_nTBI", bus.nTBI, 1);
        chk("rst_OE", bus.TERM_OE, 0);
        chk("rst_SEL", bus.WIN_SEL, 0);
        chk("rst_BUSY", bus.BUSY, 0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // External ack on win2 raised after edge 10; a stray ack on win1 is ignored.
        start(20'hE0010, 1'b1);
        for (int e = 1; e <= 14; e++) begin
            bus.EXT_ACK = (e == 11 || e == 12) ? 4'b0100 : (e == 5) ? 4'b0010 : 4'b0000;
            tick();
            chk($sformatf("ext_nTA_e%0d", e), bus.nTA, (e == 12) ? 0 : 1);
            chk($sformatf("ext_nTEA_e%0d", e), bus.nTEA, 1);
            if (e == 12) begin
                chk("ext_SEL", bus.WIN_SEL, 4'b0100);
                chk("ext_nTCI", bus.nTCI, 0);
                chk("ext_nTBI", bus.nTBI, 0);
            end
        end
        bus.EXT_ACK = '0;

        // No external ack: 255 wait cycles, then nTEA.
        start(20'hE0010, 1'b1);
        cnt_ta = 0;
        for (int e = 1; e <= 259; e++) begin
            tick();
            if (!bus.nTA) cnt_ta++;
            if (e == 256) chk("to_nTEA_early", bus.nTEA, 1);
            if (e == 257) begin
                chk("to_nTEA", bus.nTEA, 0);
                chk("to_SEL", bus.WIN_SEL, 4'b0100);
                chk("to_nTCI", bus.nTCI, 1);
                chk("to_OE", bus.TERM_OE, 1);
            end
            if (e == 258) chk("to_nTEA_neg", bus.nTEA, 1);
        end
        chk("to_no_nTA", cnt_ta, 0);
        chk("to_BUSY_end", bus.BUSY, 0);

        // nTS pulsed during WAIT must not start a second transfer.
        start(20'hBFD12, 1'b1);
        cnt_ta = 0; last_e = 0;
        for (int e = 1; e <= 12; e++) begin
            bus.nTS = (e == 3) ? 1'b0 : 1'b1;
            tick();
            if (!bus.nTA) begin cnt_ta++; last_e = e; end
        end
        chk("ign_ack_count", cnt_ta, 1);
        chk("ign_ack_edge", last_e, 5);
        chk("ign_BUSY_end", bus.BUSY, 0);

        // Second nTS sampled in the first IDLE cycle after NEGATE.
        start(20'h00F85, 1'b1);
        bus.A = 20'hBFD12;
        cnt_ta = 0; first_e = 0; second_e = 0;
        for (int e = 1; e <= 12; e++) begin
            bus.nTS = (e == 4) ? 1'b0 : 1'b1;
            tick();
            if (!bus.nTA) begin
                cnt_ta++;
                if (first_e == 0) first_e = e;
                else              second_e = e;
            end
        end
        chk("b2b_ack_count", cnt_ta, 2);
        chk("b2b_first_edge", first_e, 2);
        chk("b2b_second_edge", second_e, 9);

        // Reset asserted mid-WAIT aborts with no ack afterwards.
        start(20'hBF123, 1'b1);
        tick(); tick(); tick();
        chk("abort_SEL_pre", bus.WIN_SEL, 4'b1000);
        chk("abort_BUSY_pre", bus.BUSY, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_SEL", bus.WIN_SEL, 0);
        chk("abort_BUSY", bus.BUSY, 0);
        chk("abort_OE", bus.TERM_OE, 0);
        chk("abort_nTA", bus.nTA, 1);
        tick();
        rst = 1'b0;
        cnt_ta = 0; cnt_tea = 0;
        for (int e = 0; e < 25; e++) begin
            tick();
            if (!bus.nTA) cnt_ta++;
            if (!bus.nTEA) cnt_tea++;
        end
        chk("abort_no_nTA", cnt_ta, 0);
        chk("abort_no_nTEA", cnt_tea, 0);
        chk("abort_BUSY_end", bus.BUSY, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
